// File: rtl/tile_query_arbiter.sv
// rtl/tile_query_arbiter.sv - two-requester round-robin arbiter in front of the combinational tile-type ROM
module tile_query_arbiter #(
  parameter int         NUM_COLS   = 15,
  parameter int         NUM_ROWS   = 8,
  parameter logic [3:0] FLOOR_TYPE = 4'd7,
  parameter logic [3:0] OOB_TYPE   = 4'hF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       p1_req_valid,
  output logic       p1_req_ready,
  input  logic [3:0] p1_col,
  input  logic [2:0] p1_row,
  input  logic       p2_req_valid,
  output logic       p2_req_ready,
  input  logic [3:0] p2_col,
  input  logic [2:0] p2_row,
  output logic [6:0] tile_index,
  input  logic [3:0] tile_type_in,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [3:0] resp_type,
  output logic       resp_walkable,
  output logic       resp_oob
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOKUP  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_last_grant;
  logic       r_req_id;
  logic       r_req_oob;
  logic [6:0] r_tile_index;
  logic       r_resp_valid;
  logic       r_resp_id;
  logic [3:0] r_resp_type;
  logic       r_resp_walkable;
  logic       r_resp_oob;

  logic       w_grant_valid;
  logic       w_grant_id;
  logic       w_accept;
  logic [3:0] w_sel_col;
  logic [2:0] w_sel_row;
  logic       w_sel_oob;
  logic [6:0] w_sel_index;

  // Grant selection: a lone requester wins, a tie goes to whoever was not served last
  always_comb begin
    w_grant_valid = p1_req_valid | p2_req_valid;
    w_grant_id    = 1'b0;
    if (p1_req_valid && p2_req_valid) begin
      w_grant_id = ~r_last_grant;
    end else if (p2_req_valid) begin
      w_grant_id = 1'b1;
    end
  end

  // Readies are held low while reset is asserted even though the state already reads IDLE
  assign w_accept     = reset_n && (r_state == S_IDLE) && w_grant_valid;
  assign p1_req_ready = w_accept & ~w_grant_id;
  assign p2_req_ready = w_accept &  w_grant_id;

  assign w_sel_col   = w_grant_id ? p2_col : p1_col;
  assign w_sel_row   = w_grant_id ? p2_row : p1_row;
  assign w_sel_oob   = (w_sel_col >= 4'(NUM_COLS)) || ({1'b0, w_sel_row} >= 4'(NUM_ROWS));
  assign w_sel_index = 7'(w_sel_row) * 7'(NUM_COLS) + 7'(w_sel_col);

  // Next-state logic for the single-outstanding IDLE -> LOOKUP -> RESPOND loop
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next_state = S_LOOKUP;
      S_LOOKUP:  w_next_state = S_RESPOND;
      S_RESPOND: if (r_resp_valid && resp_ready) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request capture: out-of-range requests leave the ROM address where it was
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_req_id     <= 1'b0;
      r_req_oob    <= 1'b0;
      r_tile_index <= 7'd0;
    end else if (r_state == S_IDLE && w_accept) begin
      r_last_grant <= w_grant_id;
      r_req_id     <= w_grant_id;
      r_req_oob    <= w_sel_oob;
      if (!w_sel_oob) begin
        r_tile_index <= w_sel_index;
      end
    end
  end

  // Response register: loaded from the ROM in LOOKUP, held until the consumer takes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_valid    <= 1'b0;
      r_resp_id       <= 1'b0;
      r_resp_type     <= 4'd0;
      r_resp_walkable <= 1'b0;
      r_resp_oob      <= 1'b0;
    end else if (r_state == S_LOOKUP) begin
      r_resp_valid    <= 1'b1;
      r_resp_id       <= r_req_id;
      r_resp_type     <= r_req_oob ? OOB_TYPE : tile_type_in;
      r_resp_walkable <= !r_req_oob && (tile_type_in == FLOOR_TYPE);
      r_resp_oob      <= r_req_oob;
    end else if (r_state == S_RESPOND && r_resp_valid && resp_ready) begin
      r_resp_valid    <= 1'b0;
    end
  end

  assign tile_index    = r_tile_index;
  assign resp_valid    = r_resp_valid;
  assign resp_id       = r_resp_id;
  assign resp_type     = r_resp_type;
  assign resp_walkable = r_resp_walkable;
  assign resp_oob      = r_resp_oob;

endmodule

// File: tb/tb_tile_query_arbiter.sv
// tb/tb_tile_query_arbiter.sv - directed vector bench for tile_query_arbiter
module tb_tile_query_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       p1_req_valid, p2_req_valid;
  logic       p1_req_ready, p2_req_ready;
  logic [3:0] p1_col, p2_col;
  logic [2:0] p1_row, p2_row;
  logic [6:0] tile_index;
  logic [3:0] tile_type_in;
  logic       resp_valid, resp_ready, resp_id, resp_walkable, resp_oob;
  logic [3:0] resp_type;

  int total = 0;
  int bad   = 0;
  int cur_vec = -1;

  tile_query_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_col(p1_col), .p1_row(p1_row),
    .p2_req_valid(p2_req_valid), .p2_req_ready(p2_req_ready), .p2_col(p2_col), .p2_row(p2_row),
    .tile_index(tile_index), .tile_type_in(tile_type_in),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_type(resp_type), .resp_walkable(resp_walkable), .resp_oob(resp_oob)
  );

  always #5 clk = ~clk;

  // Kitchen map stand-in: named tiles at known indices, everything else type 1
  function automatic logic [3:0] rom_type(input logic [6:0] idx);
    case (idx)
      7'd3:    rom_type = 4'd2;
      7'd11:   rom_type = 4'd3;
      7'd104:  rom_type = 4'd6;
      7'd65:   rom_type = 4'd7;
      7'd44:   rom_type = 4'd10;
      7'd60:   rom_type = 4'd9;
      7'd109:  rom_type = 4'd0;
      7'd75:   rom_type = 4'd8;
      default: rom_type = 4'd1;
    endcase
  endfunction

  assign tile_type_in = rom_type(tile_index);

  typedef struct {
    logic       p1v;
    logic [3:0] p1c;
    logic [2:0] p1r;
    logic       p2v;
    logic [3:0] p2c;
    logic [2:0] p2r;
    logic       eid;
    logic [3:0] etype;
    logic       ewalk;
    logic       eoob;
    logic [6:0] eidx;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (vec %0d) got=%0h want=%0h", name, cur_vec, act, exp);
    end
  endtask

  task automatic drop_reqs();
    p1_req_valid = 1'b0;
    p2_req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bit   got;
    logic gid;
    got = 1'b0;
    gid = 1'b0;
    @(negedge clk);
    p1_req_valid = v.p1v; p1_col = v.p1c; p1_row = v.p1r;
    p2_req_valid = v.p2v; p2_col = v.p2c; p2_row = v.p2r;
    resp_ready   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("ready_exclusive", 32'(p1_req_ready & p2_req_ready), 32'd0);
      if ((p1_req_valid && p1_req_ready) || (p2_req_valid && p2_req_ready)) begin
        got = 1'b1;
        gid = p2_req_ready;
        break;
      end
      @(negedge clk);
    end
    chk("accepted", 32'(got), 32'd1);
    if (!got) begin
      drop_reqs();
      return;
    end
    chk("grant_id", 32'(gid), 32'(v.eid));
    @(negedge clk);
    drop_reqs();
    #1;
    chk("lookup_resp_valid", 32'(resp_valid), 32'd0);
    chk("tile_index", 32'(tile_index), 32'(v.eidx));
    @(negedge clk);
    #1;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_id", 32'(resp_id), 32'(v.eid));
    chk("resp_type", 32'(resp_type), 32'(v.etype));
    chk("resp_walkable", 32'(resp_walkable), 32'(v.ewalk));
    chk("resp_oob", 32'(resp_oob), 32'(v.eoob));
    @(negedge clk);
    #1;
    chk("resp_valid_after_hs", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    //           p1v p1c    p1r   p2v p2c    p2r   id    type   walk  oob   idx
    vecs[0]  = '{1'b1, 4'd11, 3'd0, 1'b1, 4'd14, 3'd6, 1'b0, 4'd3,  1'b0, 1'b0, 7'd11};
    vecs[1]  = '{1'b1, 4'd11, 3'd0, 1'b1, 4'd14, 3'd6, 1'b1, 4'd6,  1'b0, 1'b0, 7'd104};
    vecs[2]  = '{1'b1, 4'd3,  3'd0, 1'b0, 4'd0,  3'd0, 1'b0, 4'd2,  1'b0, 1'b0, 7'd3};
    vecs[3]  = '{1'b0, 4'd0,  3'd0, 1'b1, 4'd15, 3'd2, 1'b1, 4'hF,  1'b0, 1'b1, 7'd3};
    vecs[4]  = '{1'b1, 4'd14, 3'd2, 1'b0, 4'd0,  3'd0, 1'b0, 4'd10, 1'b0, 1'b0, 7'd44};
    vecs[5]  = '{1'b0, 4'd0,  3'd0, 1'b1, 4'd0,  3'd4, 1'b1, 4'd9,  1'b0, 1'b0, 7'd60};
    vecs[6]  = '{1'b1, 4'd4,  3'd7, 1'b0, 4'd0,  3'd0, 1'b0, 4'd0,  1'b0, 1'b0, 7'd109};
    vecs[7]  = '{1'b0, 4'd0,  3'd0, 1'b1, 4'd0,  3'd5, 1'b1, 4'd8,  1'b0, 1'b0, 7'd75};
    vecs[8]  = '{1'b1, 4'd5,  3'd4, 1'b1, 4'd0,  3'd0, 1'b0, 4'd7,  1'b1, 1'b0, 7'd65};
    vecs[9]  = '{1'b1, 4'd1,  3'd1, 1'b1, 4'd2,  3'd1, 1'b1, 4'd1,  1'b0, 1'b0, 7'd17};
    vecs[10] = '{1'b1, 4'd15, 3'd7, 1'b0, 4'd0,  3'd0, 1'b0, 4'hF,  1'b0, 1'b1, 7'd17};

    reset_n = 1'b0;
    drop_reqs();
    p1_col = 4'd0; p1_row = 3'd0; p2_col = 4'd0; p2_row = 3'd0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    p1_req_valid = 1'b1;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_type", 32'(resp_type), 32'd0);
    chk("rst_resp_walkable", 32'(resp_walkable), 32'd0);
    chk("rst_resp_oob", 32'(resp_oob), 32'd0);
    chk("rst_tile_index", 32'(tile_index), 32'd0);
    chk("rst_p1_ready", 32'(p1_req_ready), 32'd0);
    drop_reqs();
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // Back-pressure: response must hold still and no new grant while it waits
    cur_vec = 100;
    @(negedge clk);
    p1_req_valid = 1'b1; p1_col = 4'd5; p1_row = 3'd4;
    resp_ready = 1'b0;
    #1;
    chk("bp_p1_ready", 32'(p1_req_ready), 32'd1);
    @(negedge clk);
    drop_reqs();
    p2_req_valid = 1'b1; p2_col = 4'd2; p2_row = 3'd2;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_resp_type", 32'(resp_type), 32'd7);
      chk("bp_resp_walkable", 32'(resp_walkable), 32'd1);
      chk("bp_resp_id", 32'(resp_id), 32'd0);
      chk("bp_readies", 32'({p1_req_ready, p2_req_ready}), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_release_valid", 32'(resp_valid), 32'd0);
    chk("bp_idle_p2_ready", 32'(p2_req_ready), 32'd1);
    drop_reqs();
    @(negedge clk);
    #1;
    chk("drop_no_effect", 32'(resp_valid), 32'd0);

    // Reset during LOOKUP discards the request; a fresh request still works afterwards
    cur_vec = 200;
    @(negedge clk);
    p1_req_valid = 1'b1; p1_col = 4'd3; p1_row = 3'd0;
    resp_ready = 1'b1;
    #1;
    chk("mid_p1_ready", 32'(p1_req_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_readies", 32'({p1_req_ready, p2_req_ready}), 32'd0);
    chk("mid_rst_tile_index", 32'(tile_index), 32'd0);
    @(negedge clk);
    drop_reqs();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("mid_no_resp", 32'(resp_valid), 32'd0);
    end
    cur_vec = 201;
    run_vec('{1'b1, 4'd4, 3'd7, 1'b1, 4'd0, 3'd4, 1'b0, 4'd0, 1'b0, 1'b0, 7'd109});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
